// File: rtl/amiga_kbd_pkg.sv
// Shared codes, state encoding and byte encoding for the Amiga keyboard serial link.
package amiga_kbd_pkg;

   typedef enum logic [2:0] {
      PU_FD, PU_FE, IDLE, SHIFT, WAIT_HS, HS_RELEASE, RESYNC, LOSTSYNC
   } kbd_state_t;

   // What the byte currently on the wire is, so the handshake knows what comes next.
   typedef enum logic [1:0] {
      CUR_FD, CUR_FE, CUR_KEY, CUR_LOST
   } kbd_kind_t;

   localparam logic [7:0] CODE_PWR_INIT = 8'hFD;
   localparam logic [7:0] CODE_PWR_TERM = 8'hFE;
   localparam logic [7:0] CODE_LOSTSYNC = 8'hF9;

   // Release flag rotates to the end of the byte; the line carries the inverse.
   function automatic logic [7:0] kbd_encode(input logic [7:0] b);
      return {b[6:0], b[7]};
   endfunction

endpackage

// File: rtl/kbd_hs_detect.sv
// Host handshake detector: synchronizes kdat_i and counts consecutive low samples.
module kbd_hs_detect #(
   parameter int HS_TICKS = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic kdat_i,
   input  logic clr,
   output logic kdat_s,
   output logic hs_seen
);

   localparam int CW = $clog2(HS_TICKS + 1);

   logic          kdat_meta;
   logic [CW-1:0] low_cnt;

   // Line idles high, so the synchronizer resets to the released level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kdat_meta <= 1'b1;
         kdat_s    <= 1'b1;
      end else begin
         kdat_meta <= kdat_i;
         kdat_s    <= kdat_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         low_cnt <= '0;
      else if (clr || kdat_s)
         low_cnt <= '0;
      else if (low_cnt != CW'(HS_TICKS))
         low_cnt <= low_cnt + 1'b1;
   end

   assign hs_seen = (low_cnt == CW'(HS_TICKS));

endmodule

// File: rtl/amiga_kbd_serial.sv
// Amiga keyboard serial transmitter: power-up codes, key bytes, handshake, resync/lost-sync recovery.
module amiga_kbd_serial
   import amiga_kbd_pkg::*;
#(
   parameter int BIT_TICKS     = 142,
   parameter int TIMEOUT_TICKS = 1014412,
   parameter int HS_TICKS      = 8
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       keystrobe,
   input  logic [7:0] keydat,
   output logic       keyack,
   output logic       kclk_o,
   output logic       kdat_o,
   input  logic       kdat_i
);

   localparam int TW = $clog2(3 * BIT_TICKS);
   localparam logic [TW-1:0] TICK_LOW  = TW'(BIT_TICKS);
   localparam logic [TW-1:0] TICK_HIGH = TW'(2 * BIT_TICKS);
   localparam logic [TW-1:0] TICK_LAST = TW'(3 * BIT_TICKS - 1);
   localparam logic [19:0]   TO_LAST   = 20'(TIMEOUT_TICKS - 1);

   kbd_state_t    state, state_nxt;
   kbd_kind_t     cur_kind, cur_kind_nxt, ret_kind, ret_kind_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic [2:0]    bitcnt, bitcnt_nxt;
   logic [19:0]   tcnt, tcnt_nxt;
   logic          lost, lost_nxt;
   logic          pend_full, pend_clr, pend_load;
   logic          kclk_nxt, kdat_nxt, keyack_nxt;
   logic          load_en, shift_en, save_ret, hs_clr;
   logic [7:0]    load_code, sreg, cur_code, ret_code, pend_code;
   logic          kdat_s, hs_seen;

   kbd_hs_detect #(.HS_TICKS(HS_TICKS)) u_hs (
      .clk    (clk),
      .reset_n(reset_n),
      .kdat_i (kdat_i),
      .clr    (hs_clr),
      .kdat_s (kdat_s),
      .hs_seen(hs_seen)
   );

   assign pend_load = keystrobe && !pend_full;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= PU_FD;
         cur_kind  <= CUR_FD;
         ret_kind  <= CUR_FD;
         tick      <= '0;
         bitcnt    <= '0;
         tcnt      <= '0;
         lost      <= 1'b0;
         pend_full <= 1'b0;
         kclk_o    <= 1'b1;
         kdat_o    <= 1'b1;
         keyack    <= 1'b0;
      end else begin
         state     <= state_nxt;
         cur_kind  <= cur_kind_nxt;
         ret_kind  <= ret_kind_nxt;
         tick      <= tick_nxt;
         bitcnt    <= bitcnt_nxt;
         tcnt      <= tcnt_nxt;
         lost      <= lost_nxt;
         pend_full <= pend_clr ? 1'b0 : (pend_full | pend_load);
         kclk_o    <= kclk_nxt;
         kdat_o    <= kdat_nxt;
         keyack    <= keyack_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (load_en)
         sreg <= kbd_encode(load_code);
      else if (shift_en)
         sreg <= {sreg[6:0], 1'b0};
      if (load_en)
         cur_code <= load_code;
      if (save_ret)
         ret_code <= cur_code;
      if (pend_load)
         pend_code <= keydat;
   end

   always_comb begin
      state_nxt    = state;
      cur_kind_nxt = cur_kind;
      ret_kind_nxt = ret_kind;
      tick_nxt     = tick;
      bitcnt_nxt   = bitcnt;
      tcnt_nxt     = '0;
      lost_nxt     = lost;
      pend_clr     = 1'b0;
      kclk_nxt     = 1'b1;
      kdat_nxt     = 1'b1;
      keyack_nxt   = 1'b0;
      load_en      = 1'b0;
      load_code    = cur_code;
      shift_en     = 1'b0;
      save_ret     = 1'b0;
      hs_clr       = 1'b1;

      case (state)
         PU_FD: begin
            load_en      = 1'b1;
            load_code    = CODE_PWR_INIT;
            cur_kind_nxt = CUR_FD;
            tick_nxt     = '0;
            bitcnt_nxt   = '0;
            state_nxt    = SHIFT;
         end
         PU_FE: begin
            load_en      = 1'b1;
            load_code    = CODE_PWR_TERM;
            cur_kind_nxt = CUR_FE;
            tick_nxt     = '0;
            bitcnt_nxt   = '0;
            state_nxt    = SHIFT;
         end
         IDLE: begin
            if (pend_full) begin
               load_en      = 1'b1;
               load_code    = pend_code;
               cur_kind_nxt = CUR_KEY;
               tick_nxt     = '0;
               bitcnt_nxt   = '0;
               state_nxt    = SHIFT;
            end
         end
         SHIFT: begin
            kdat_nxt = ~sreg[7];
            kclk_nxt = !(tick >= TICK_LOW && tick < TICK_HIGH);
            if (tick == TICK_LAST) begin
               tick_nxt = '0;
               if (bitcnt == 3'd7) begin
                  state_nxt = WAIT_HS;
               end else begin
                  bitcnt_nxt = bitcnt + 3'd1;
                  shift_en   = 1'b1;
               end
            end else begin
               tick_nxt = tick + 1'b1;
            end
         end
         WAIT_HS: begin
            hs_clr   = 1'b0;
            tcnt_nxt = tcnt + 20'd1;
            if (hs_seen) begin
               state_nxt = HS_RELEASE;
            end else if (tcnt == TO_LAST) begin
               tick_nxt  = '0;
               state_nxt = RESYNC;
            end
         end
         HS_RELEASE: begin
            if (kdat_s) begin
               if (lost) begin
                  state_nxt = LOSTSYNC;
               end else begin
                  case (cur_kind)
                     CUR_FD:  state_nxt = PU_FE;
                     CUR_FE:  state_nxt = IDLE;
                     CUR_KEY: begin
                        keyack_nxt = 1'b1;
                        pend_clr   = 1'b1;
                        state_nxt  = IDLE;
                     end
                     default: begin
                        // Lost-sync byte accepted: resend the interrupted byte from its first bit.
                        load_en      = 1'b1;
                        load_code    = ret_code;
                        cur_kind_nxt = ret_kind;
                        tick_nxt     = '0;
                        bitcnt_nxt   = '0;
                        state_nxt    = SHIFT;
                     end
                  endcase
               end
            end
         end
         RESYNC: begin
            kdat_nxt = 1'b0;
            kclk_nxt = !(tick >= TICK_LOW && tick < TICK_HIGH);
            if (tick == TICK_LAST) begin
               tick_nxt  = '0;
               lost_nxt  = 1'b1;
               state_nxt = WAIT_HS;
            end else begin
               tick_nxt = tick + 1'b1;
            end
         end
         LOSTSYNC: begin
            lost_nxt = 1'b0;
            // A repeated lost-sync must not overwrite the byte still owed to the host.
            if (cur_kind != CUR_LOST) begin
               save_ret     = 1'b1;
               ret_kind_nxt = cur_kind;
            end
            load_en      = 1'b1;
            load_code    = CODE_LOSTSYNC;
            cur_kind_nxt = CUR_LOST;
            tick_nxt     = '0;
            bitcnt_nxt   = '0;
            state_nxt    = SHIFT;
         end
         default: state_nxt = PU_FD;
      endcase
   end

endmodule

// File: tb/tb_amiga_kbd_serial.sv
// Bench for amiga_kbd_serial: decodes the line at each kclk_o fall and checks it against expected bits.
module tb_amiga_kbd_serial;

   localparam int BT = 4;
   localparam int TO = 300;
   localparam int HS = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       keystrobe = 1'b0;
   logic [7:0] keydat = 8'h00;
   logic       kdat_i = 1'b1;
   logic       keyack, kclk_o, kdat_o;

   int   vectors = 0;
   int   miscompares = 0;
   int   ack_cnt = 0;
   logic exp_q[$];

   always #5 clk = ~clk;

   amiga_kbd_serial #(.BIT_TICKS(BT), .TIMEOUT_TICKS(TO), .HS_TICKS(HS)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .keystrobe(keystrobe),
      .keydat   (keydat),
      .keyack   (keyack),
      .kclk_o   (kclk_o),
      .kdat_o   (kdat_o),
      .kdat_i   (kdat_i)
   );

   // Model: line byte is the inverse of the rotated key byte, MSB first.
   function automatic logic [7:0] line_byte(input logic [7:0] b);
      return ~{b[6:0], b[7]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
   endtask

   task automatic wait_left(input int left, input int budget, input string name);
      int n = 0;
      while (exp_q.size() > left && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() > left) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: timed out with %0d line bits outstanding", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic strobe(input logic [7:0] b);
      @(posedge clk); #1;
      keydat = b;
      keystrobe = 1'b1;
      @(posedge clk); #1;
      keystrobe = 1'b0;
   endtask

   task automatic handshake();
      repeat (2 * BT + 4) @(posedge clk);
      #1 kdat_i = 1'b0;
      repeat (20) @(posedge clk);
      #1 kdat_i = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   // Monitor: every falling kclk_o edge carries one expected line bit.
   initial begin
      logic prev_kclk, prev_ack, cur_bit, e;
      int   low_len;
      bit   in_low;
      prev_kclk = 1'b1; prev_ack = 1'b0; cur_bit = 1'b1; low_len = 0; in_low = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_low = 0; prev_kclk = 1'b1; prev_ack = 1'b0;
         end else begin
            if (prev_kclk && !kclk_o) begin
               in_low = 1; low_len = 1; cur_bit = kdat_o;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_bit: got line bit %0b, expected no transfer", kdat_o);
               end else begin
                  e = exp_q.pop_front();
                  chk("line_bit", 32'(kdat_o), 32'(e));
               end
            end else if (!kclk_o && in_low) begin
               low_len++;
               chk("kdat_stable_low", 32'(kdat_o), 32'(cur_bit));
            end else if (kclk_o && !prev_kclk && in_low) begin
               chk("kclk_low_len", 32'(low_len), 32'(BT));
               in_low = 0;
            end
            if (keyack) begin
               if (prev_ack) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL keyack_width: got high 2+ cycles, expected 1");
               end
               ack_cnt++;
            end
            prev_kclk = kclk_o;
            prev_ack = keyack;
         end
      end
   end

   initial begin
      logic [7:0] kin [5];
      logic [7:0] kexp[5];
      kin  = '{8'h45, 8'hC5, 8'hFD, 8'hFE, 8'hF9};
      kexp = '{8'h75, 8'h74, 8'h04, 8'h02, 8'h0C};
      for (int i = 0; i < 5; i++) chk("model_pin", 32'(line_byte(kin[i])), 32'(kexp[i]));

      // Reset state and power-up sequence
      @(posedge clk); #1;
      chk("rst_kclk", 32'(kclk_o), 32'd1);
      chk("rst_kdat", 32'(kdat_o), 32'd1);
      chk("rst_keyack", 32'(keyack), 32'd0);
      push_byte(line_byte(8'hFD));
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      wait_left(0, 200, "pwr_fd");
      push_byte(line_byte(8'hFE));
      handshake();
      wait_left(0, 200, "pwr_fe");
      handshake();
      chk("pwr_no_ack", 32'(ack_cnt), 32'd0);

      // Key 0x45 with a second strobe dropped mid-transfer
      strobe(8'h45);
      push_byte(line_byte(8'h45));
      wait_left(5, 200, "key45_mid");
      strobe(8'h46);
      wait_left(0, 200, "key45");
      chk("key45_no_early_ack", 32'(ack_cnt), 32'd0);
      handshake();
      chk("key45_ack", 32'(ack_cnt), 32'd1);
      repeat (150) @(posedge clk);
      chk("drop46_idle_kclk", 32'(kclk_o), 32'd1);
      chk("drop46_ack", 32'(ack_cnt), 32'd1);

      // Key 0xC5 (release flag set)
      strobe(8'hC5);
      push_byte(line_byte(8'hC5));
      wait_left(0, 200, "keyc5");
      handshake();
      chk("keyc5_ack", 32'(ack_cnt), 32'd2);

      // Timeout -> resync bit -> lost-sync -> resend
      strobe(8'h45);
      push_byte(line_byte(8'h45));
      wait_left(0, 200, "key45b");
      exp_q.push_back(1'b0);
      wait_left(0, TO + 100, "resync_bit");
      chk("resync_no_ack", 32'(ack_cnt), 32'd2);
      push_byte(line_byte(8'hF9));
      handshake();
      wait_left(0, 200, "lostsync");
      chk("lostsync_no_ack", 32'(ack_cnt), 32'd2);
      push_byte(line_byte(8'h45));
      handshake();
      wait_left(0, 200, "resend45");
      handshake();
      chk("resend_ack", 32'(ack_cnt), 32'd3);

      // Reset in the middle of bit 3
      strobe(8'h45);
      push_byte(line_byte(8'h45));
      wait_left(4, 200, "key45_rst");
      repeat (2 * BT + 2) @(posedge clk);
      #1 chk("pre_reset_bit3", 32'(kdat_o), 32'd0);
      #1 reset_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_kclk", 32'(kclk_o), 32'd1);
      chk("midrst_kdat", 32'(kdat_o), 32'd1);
      chk("midrst_keyack", 32'(keyack), 32'd0);
      push_byte(line_byte(8'hFD));
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      wait_left(0, 200, "re_fd");
      push_byte(line_byte(8'hFE));
      handshake();
      wait_left(0, 200, "re_fe");
      handshake();
      repeat (150) @(posedge clk);
      chk("re_no_ack", 32'(ack_cnt), 32'd3);
      chk("re_idle_kdat", 32'(kdat_o), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
